hack_alu: RTL and testbench

- Registered 16-bit Hack-style ALU, the compute stage of the CPU datapath.
- Each operand is conditioned by the zero and negate controls. The block then adds or ANDs the two operands and optionally inverts the result.
- The result and its zero/negative flags are registered one cycle later, qualified by a valid strobe.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/hack_alu_if.sv | 28 ++
 rtl/alu_core.sv | 33 +++
 rtl/hack_alu.sv | 71 +++++++
 tb/tb_hack_alu.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the Hack ALU: default width, control word and canonical encodings.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    // Control word, MSB first: zx nx zy ny f no
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_ZERO    = 6'b101010;
    localparam alu_ctrl_t ALU_ONE     = 6'b111111;
    localparam alu_ctrl_t ALU_NEG1    = 6'b111010;
    localparam alu_ctrl_t ALU_X       = 6'b001100;
    localparam alu_ctrl_t ALU_Y       = 6'b110000;
    localparam alu_ctrl_t ALU_NOT_X   = 6'b001101;
    localparam alu_ctrl_t ALU_NOT_Y   = 6'b110001;
    localparam alu_ctrl_t ALU_NEG_X   = 6'b001111;
    localparam alu_ctrl_t ALU_NEG_Y   = 6'b110011;
    localparam alu_ctrl_t ALU_X_INC   = 6'b011111;
    localparam alu_ctrl_t ALU_Y_INC   = 6'b110111;
    localparam alu_ctrl_t ALU_X_DEC   = 6'b001110;
    localparam alu_ctrl_t ALU_Y_DEC   = 6'b110010;
    localparam alu_ctrl_t ALU_X_ADD_Y = 6'b000010;
    localparam alu_ctrl_t ALU_X_SUB_Y = 6'b010011;
    localparam alu_ctrl_t ALU_Y_SUB_X = 6'b000111;
    localparam alu_ctrl_t ALU_X_AND_Y = 6'b000000;
    localparam alu_ctrl_t ALU_X_OR_Y  = 6'b010101;

endpackage

// File: rtl/hack_alu_if.sv
// Operand/control/result bundle between the datapath (master) and the ALU stage (slave).
interface hack_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid_i;
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] y_i;
    logic             zx_i;
    logic             nx_i;
    logic             zy_i;
    logic             ny_i;
    logic             f_i;
    logic             no_i;
    logic [WIDTH-1:0] out_o;
    logic             zr_o;
    logic             ng_o;
    logic             valid_o;

    modport master (
        output valid_i, x_i, y_i, zx_i, nx_i, zy_i, ny_i, f_i, no_i,
        input  out_o, zr_o, ng_o, valid_o
    );

    modport slave (
        input  valid_i, x_i, y_i, zx_i, nx_i, zy_i, ny_i, f_i, no_i,
        output out_o, zr_o, ng_o, valid_o
    );
endinterface

// File: rtl/alu_core.sv
// Combinational Hack ALU function: operand conditioning, add/AND, optional invert, flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  alu_ctrl_t        ctrl_i,
    output logic [WIDTH-1:0] res_c_o,
    output logic             zr_c_o,
    output logic             ng_c_o
);

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] r;

    // Zero before negate; the adder's carry-out falls off the top
    always_comb begin
        x1      = ctrl_i.zx ? '0 : x_i;
        x2      = ctrl_i.nx ? ~x1 : x1;
        y1      = ctrl_i.zy ? '0 : y_i;
        y2      = ctrl_i.ny ? ~y1 : y1;
        r       = ctrl_i.f ? WIDTH'(x2 + y2) : (x2 & y2);
        res_c_o = ctrl_i.no ? ~r : r;
        zr_c_o  = (res_c_o == '0);
        ng_c_o  = res_c_o[WIDTH-1];
    end

endmodule

// File: rtl/hack_alu.sv
// Registered Hack ALU stage: one-cycle latency, valid-gated result/flag capture.
module hack_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    hack_alu_if.slave  bus
);

    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] res_c;
    logic             zr_c;
    logic             ng_c;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             zr_q;
    logic             zr_d;
    logic             ng_q;
    logic             ng_d;
    logic             valid_q;
    logic             valid_d;

    assign ctrl = '{zx: bus.zx_i, nx: bus.nx_i, zy: bus.zy_i,
                    ny: bus.ny_i, f: bus.f_i, no: bus.no_i};

    alu_core #(.WIDTH(WIDTH)) u_core (
        .x_i     (bus.x_i),
        .y_i     (bus.y_i),
        .ctrl_i  (ctrl),
        .res_c_o (res_c),
        .zr_c_o  (zr_c),
        .ng_c_o  (ng_c)
    );

    // Hold the last result when no new operands are offered
    always_comb begin
        out_d   = out_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        valid_d = bus.valid_i;
        if (bus.valid_i) begin
            out_d = res_c;
            zr_d  = zr_c;
            ng_d  = ng_c;
        end
    end

    // Reset state mirrors a zero result: zr set, ng clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q   <= '0;
            zr_q    <= 1'b1;
            ng_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_o   = out_q;
    assign bus.zr_o    = zr_q;
    assign bus.ng_o    = ng_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_hack_alu.sv
// Directed bench for hack_alu: canonical-code sweeps, wrap-around, reset and pipelining/hold.
module tb_hack_alu;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        string      name;
        logic [W-1:0] x;
        logic [W-1:0] y;
        alu_ctrl_t  c;
        logic [W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vq[$];

    hack_alu_if #(.WIDTH(W)) bus ();

    hack_alu #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] e_out,
                                input logic e_zr, input logic e_ng, input logic e_valid);
        check({name, " out"},   32'(bus.out_o),   32'(e_out));
        check({name, " zr"},    32'(bus.zr_o),    32'(e_zr));
        check({name, " ng"},    32'(bus.ng_o),    32'(e_ng));
        check({name, " valid"}, 32'(bus.valid_o), 32'(e_valid));
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input alu_ctrl_t c);
        bus.valid_i = v;
        bus.x_i     = x;
        bus.y_i     = y;
        bus.zx_i    = c.zx;
        bus.nx_i    = c.nx;
        bus.zy_i    = c.zy;
        bus.ny_i    = c.ny;
        bus.f_i     = c.f;
        bus.no_i    = c.no;
    endtask

    task automatic add_vec(input string n, input logic [W-1:0] x, input logic [W-1:0] y,
                           input alu_ctrl_t c, input logic [W-1:0] e);
        vec_t v;
        v.name = n; v.x = x; v.y = y; v.c = c; v.exp = e;
        vq.push_back(v);
    endtask

    initial begin
        logic [W-1:0] e;
        checks = 0;
        errors = 0;

        // x=0000 y=FFFF sweep
        add_vec("a_zero", 16'h0000, 16'hFFFF, ALU_ZERO,    16'h0000);
        add_vec("a_one",  16'h0000, 16'hFFFF, ALU_ONE,     16'h0001);
        add_vec("a_neg1", 16'h0000, 16'hFFFF, ALU_NEG1,    16'hFFFF);
        add_vec("a_x",    16'h0000, 16'hFFFF, ALU_X,       16'h0000);
        add_vec("a_y",    16'h0000, 16'hFFFF, ALU_Y,       16'hFFFF);
        add_vec("a_notx", 16'h0000, 16'hFFFF, ALU_NOT_X,   16'hFFFF);
        add_vec("a_noty", 16'h0000, 16'hFFFF, ALU_NOT_Y,   16'h0000);
        add_vec("a_negx", 16'h0000, 16'hFFFF, ALU_NEG_X,   16'h0000);
        add_vec("a_negy", 16'h0000, 16'hFFFF, ALU_NEG_Y,   16'h0001);
        add_vec("a_xinc", 16'h0000, 16'hFFFF, ALU_X_INC,   16'h0001);
        add_vec("a_yinc", 16'h0000, 16'hFFFF, ALU_Y_INC,   16'h0000);
        add_vec("a_xdec", 16'h0000, 16'hFFFF, ALU_X_DEC,   16'hFFFF);
        add_vec("a_ydec", 16'h0000, 16'hFFFF, ALU_Y_DEC,   16'hFFFE);
        add_vec("a_xpy",  16'h0000, 16'hFFFF, ALU_X_ADD_Y, 16'hFFFF);
        add_vec("a_xmy",  16'h0000, 16'hFFFF, ALU_X_SUB_Y, 16'h0001);
        add_vec("a_ymx",  16'h0000, 16'hFFFF, ALU_Y_SUB_X, 16'hFFFF);
        add_vec("a_and",  16'h0000, 16'hFFFF, ALU_X_AND_Y, 16'h0000);
        add_vec("a_or",   16'h0000, 16'hFFFF, ALU_X_OR_Y,  16'hFFFF);
        // x=0011 y=0003 sweep
        add_vec("b_zero", 16'h0011, 16'h0003, ALU_ZERO,    16'h0000);
        add_vec("b_one",  16'h0011, 16'h0003, ALU_ONE,     16'h0001);
        add_vec("b_neg1", 16'h0011, 16'h0003, ALU_NEG1,    16'hFFFF);
        add_vec("b_x",    16'h0011, 16'h0003, ALU_X,       16'h0011);
        add_vec("b_y",    16'h0011, 16'h0003, ALU_Y,       16'h0003);
        add_vec("b_notx", 16'h0011, 16'h0003, ALU_NOT_X,   16'hFFEE);
        add_vec("b_noty", 16'h0011, 16'h0003, ALU_NOT_Y,   16'hFFFC);
        add_vec("b_negx", 16'h0011, 16'h0003, ALU_NEG_X,   16'hFFEF);
        add_vec("b_negy", 16'h0011, 16'h0003, ALU_NEG_Y,   16'hFFFD);
        add_vec("b_xinc", 16'h0011, 16'h0003, ALU_X_INC,   16'h0012);
        add_vec("b_yinc", 16'h0011, 16'h0003, ALU_Y_INC,   16'h0004);
        add_vec("b_xdec", 16'h0011, 16'h0003, ALU_X_DEC,   16'h0010);
        add_vec("b_ydec", 16'h0011, 16'h0003, ALU_Y_DEC,   16'h0002);
        add_vec("b_xpy",  16'h0011, 16'h0003, ALU_X_ADD_Y, 16'h0014);
        add_vec("b_xmy",  16'h0011, 16'h0003, ALU_X_SUB_Y, 16'h000E);
        add_vec("b_ymx",  16'h0011, 16'h0003, ALU_Y_SUB_X, 16'hFFF2);
        add_vec("b_and",  16'h0011, 16'h0003, ALU_X_AND_Y, 16'h0001);
        add_vec("b_or",   16'h0011, 16'h0003, ALU_X_OR_Y,  16'h0013);
        // wrap-around
        add_vec("w_pos",  16'h7FFF, 16'h0001, ALU_X_ADD_Y, 16'h8000);
        add_vec("w_carry",16'hFFFF, 16'h0001, ALU_X_ADD_Y, 16'h0000);

        // Reset state, and operations offered during reset are discarded
        rst = 1'b1;
        drive(1'b1, 16'h1234, 16'h0000, ALU_X);
        #1;
        check_result("reset_init", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_result("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, ALU_ZERO);

        // Table sweep, back-to-back valid every cycle
        foreach (vq[i]) begin
            @(negedge clk);
            drive(1'b1, vq[i].x, vq[i].y, vq[i].c);
            @(posedge clk); #1;
            e = vq[i].exp;
            check_result(vq[i].name, e, (e == 16'h0000), e[W-1], 1'b1);
        end

        // Three back-to-back ops then hold with changing operands
        @(negedge clk); drive(1'b1, 16'h0100, 16'h0023, ALU_X_ADD_Y);
        @(posedge clk); #1; check_result("pipe1", 16'h0123, 1'b0, 1'b0, 1'b1);
        @(negedge clk); drive(1'b1, 16'h0100, 16'h0023, ALU_X_SUB_Y);
        @(posedge clk); #1; check_result("pipe2", 16'h00DD, 1'b0, 1'b0, 1'b1);
        @(negedge clk); drive(1'b1, 16'h0100, 16'h0023, ALU_Y_SUB_X);
        @(posedge clk); #1; check_result("pipe3", 16'hFF23, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(1'b0, 16'h0005, 16'h0007, ALU_X_ADD_Y);
        @(posedge clk); #1; check_result("hold1", 16'hFF23, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 16'hAAAA, 16'h5555, ALU_X_OR_Y);
        @(posedge clk); #1; check_result("hold2", 16'hFF23, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation, then first capture after release
        @(negedge clk); drive(1'b1, 16'h4321, 16'h0000, ALU_X);
        @(posedge clk); #1; check_result("pre_rst", 16'h4321, 1'b0, 1'b0, 1'b1);
        #2;
        drive(1'b1, 16'h8888, 16'h0000, ALU_X);
        rst = 1'b1;
        #1;
        check_result("async_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_result("rst_discard", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h1234, 16'h0000, ALU_X);
        @(posedge clk); #1; check_result("post_rst", 16'h1234, 1'b0, 1'b0, 1'b1);
        @(negedge clk); drive(1'b0, 16'h0000, 16'h0000, ALU_ZERO);
        @(posedge clk); #1; check_result("post_idle", 16'h1234, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
